// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the BCD counter family: digit width, the two
// boundary digit codes, the per-digit command decode type and small
// helpers for validating and clamping a 4-bit digit.
package bcd_pkg;

    localparam int           BCD_W    = 4;
    localparam logic [3:0]   BCD_ZERO = 4'h0;
    localparam logic [3:0]   BCD_NINE = 4'h9;

    // Decoded per-digit action for one clock, already resolved by priority
    typedef enum logic [2:0] {
        CMD_HOLD,
        CMD_CLEAR,
        CMD_PRESET,
        CMD_LOAD,
        CMD_INC,
        CMD_DEC
    } bcd_cmd_e;

    // A 4-bit code is a legal decimal digit when it is 0..9
    function automatic logic bcd_valid(input logic [BCD_W-1:0] digit);
        return (digit <= BCD_NINE);
    endfunction

    // Returns min(digit, 9) so an illegal code is stored as the largest digit
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] digit);
        return bcd_valid(digit) ? digit : BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One decimal digit register with clear/preset/load/step and wrap-around.
// Ports:
//   clk, rst        clock and asynchronous active-high reset (clears to 0)
//   inc, dec        step this digit up/down (never both high from the top)
//   set0, set9      synchronous clear to 0 / preset to 9
//   ld, ld_digit    synchronous load; codes above 9 are stored as 9
//   q               current digit
//   is9, is0        digit currently 9 / 0, feeds the carry/borrow chain
import bcd_pkg::*;

module bcd_digit (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             set0,
    input  logic             set9,
    input  logic             ld,
    input  logic [BCD_W-1:0] ld_digit,
    output logic [BCD_W-1:0] q,
    output logic             is9,
    output logic             is0
);

    bcd_cmd_e cmd;

    // Resolve the command priority: clear, preset, load, then stepping
    always_comb begin
        cmd = CMD_HOLD;
        if (set0) begin
            cmd = CMD_CLEAR;
        end else if (set9) begin
            cmd = CMD_PRESET;
        end else if (ld) begin
            cmd = CMD_LOAD;
        end else if (inc) begin
            cmd = CMD_INC;
        end else if (dec) begin
            cmd = CMD_DEC;
        end
    end

    // Digit register; 9 wraps to 0 on a step up and 0 wraps to 9 on a step down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= BCD_ZERO;
        end else begin
            case (cmd)
                CMD_CLEAR:  q <= BCD_ZERO;
                CMD_PRESET: q <= BCD_NINE;
                CMD_LOAD:   q <= bcd_clamp(ld_digit);
                CMD_INC:    q <= (q == BCD_NINE) ? BCD_ZERO : q + 4'd1;
                CMD_DEC:    q <= (q == BCD_ZERO) ? BCD_NINE : q - 4'd1;
                default:    q <= q;
            endcase
        end
    end

    assign is9 = (q == BCD_NINE);
    assign is0 = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n
// Parametrised multi-digit BCD up/down counter built from DIGITS cascaded
// bcd_digit instances with a one-cycle ripple carry/borrow chain.
// Ports:
//   clk, rst        clock and asynchronous active-high reset (value = 0)
//   up, down        count requests; both high or both low means hold
//   set0, set9      synchronous clear to all zeros / preset to all nines
//   load            synchronous load of load_value (digit 0 in bits [3:0])
//   value           registered BCD count
//   cout, bout      combinational carry/borrow out for cascading instances
//   load_err        one-cycle flag after a load that contained a digit > 9
// Build option:
//   BCD_COUNTER_N_SATURATE_EN  defined -> count saturates at all nines /
//                              all zeros instead of wrapping.
import bcd_pkg::*;

module bcd_counter_n #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  up,
    input  logic                  down,
    input  logic                  set0,
    input  logic                  set9,
    input  logic                  load,
    input  logic [BCD_W*DIGITS-1:0] load_value,
    output logic [BCD_W*DIGITS-1:0] value,
    output logic                  cout,
    output logic                  bout,
    output logic                  load_err
);

    logic [DIGITS-1:0] is9;
    logic [DIGITS-1:0] is0;
    logic [DIGITS-1:0] inc;
    logic [DIGITS-1:0] dec;
    logic [BCD_W-1:0]  digit_q [DIGITS];
    logic              all9;
    logic              all0;
    logic              up_req;
    logic              down_req;
    logic              step_up;
    logic              step_down;
    logic              load_bad;

    assign all9     = &is9;
    assign all0     = &is0;
    assign up_req   = up & ~down;
    assign down_req = down & ~up;

    // Carry/borrow are raised whenever the request meets the boundary,
    // even if a set/load wins this cycle, so a cascade stays consistent
    assign cout = up_req & all9;
    assign bout = down_req & all0;

`ifdef BCD_COUNTER_N_SATURATE_EN
    // Saturating build: a step that would wrap is simply not applied
    assign step_up   = up_req & ~all9;
    assign step_down = down_req & ~all0;
`else
    assign step_up   = up_req;
    assign step_down = down_req;
`endif

    // Ripple chain: digit i steps only when every lower digit sits at its
    // boundary (9 going up, 0 going down)
    always_comb begin
        inc    = '0;
        dec    = '0;
        inc[0] = step_up;
        dec[0] = step_down;
        for (int i = 1; i < DIGITS; i++) begin
            inc[i] = inc[i-1] & is9[i-1];
            dec[i] = dec[i-1] & is0[i-1];
        end
    end

    // Any out-of-range digit in the load word makes the load "bad"
    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_valid(load_value[BCD_W*i +: BCD_W])) begin
                load_bad = 1'b1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : gen_digit
            bcd_digit u_digit (
                .clk      (clk),
                .rst      (rst),
                .inc      (inc[g]),
                .dec      (dec[g]),
                .set0     (set0),
                .set9     (set9),
                .ld       (load),
                .ld_digit (load_value[BCD_W*g +: BCD_W]),
                .q        (digit_q[g]),
                .is9      (is9[g]),
                .is0      (is0[g])
            );
        end
    endgenerate

    // Pack the digit registers into the output word, digit 0 lowest
    always_comb begin
        value = '0;
        for (int i = 0; i < DIGITS; i++) begin
            value[BCD_W*i +: BCD_W] = digit_q[i];
        end
    end

    // load_err reflects only the load that actually took effect; set0/set9
    // outrank load and therefore never flag an error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & ~set0 & ~set9 & load_bad;
        end
    end

endmodule
